// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner
//   Time-multiplexed column driver for a 5x7 LED matrix. The five column
//   images and the display state are latched at the start of every frame.
//   Each column is lit for CYCLES_PER_COLUMN clocks, from column 4 down to
//   column 0. When the latched state is the error code, the row data blinks
//   with a half-period of BLINK_FRAMES frames.
//
// Ports
//   clock               system clock, rising edge
//   reset_n             synchronous active-low reset
//   enable              1 = scan, 0 = blank and idle
//   state[2:0]          display state code, 3'b010 = error
//   column_4..column_0  row patterns per column, active-low (0 = lit)
//   column_select[4:0]  one-hot column drive, bit 4 = column_4 (registered)
//   row[6:0]            active-low row data for the lit column (registered)
//   frame_done          one-cycle pulse when column 4 is re-entered
module matrix_column_scanner #(
    parameter int CYCLES_PER_COLUMN = 50000,
    parameter int BLINK_FRAMES      = 50
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [2:0] state,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [4:0] column_select,
    output logic [6:0] row,
    output logic       frame_done
);

    localparam int PW = (CYCLES_PER_COLUMN > 1) ? $clog2(CYCLES_PER_COLUMN) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CYCLES_PER_COLUMN - 1);
    localparam logic [FW-1:0] FRAME_LAST    = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    STATE_ERROR   = 3'b010;
    localparam logic [2:0]    INDEX_FIRST   = 3'd4;
    localparam logic [6:0]    ROW_BLANK     = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } mode_t;

    mode_t             mode_r,        mode_s;
    logic [PW-1:0]     prescaler_r,   prescaler_s;
    logic [2:0]        index_r,       index_s;
    logic [4:0][6:0]   shadow_r,      shadow_s;
    logic [2:0]        shadow_state_r, shadow_state_s;
    logic [FW-1:0]     frame_count_r, frame_count_s;
    logic              blink_on_r,    blink_on_s;
    logic              frame_pulse_s;
    logic [4:0]        column_select_s;
    logic [6:0]        row_s;

    // Next-state logic for the scan FSM, counters and image latch.
    always_comb begin
        mode_s         = mode_r;
        prescaler_s    = prescaler_r;
        index_s        = index_r;
        shadow_s       = shadow_r;
        shadow_state_s = shadow_state_r;
        frame_count_s  = frame_count_r;
        blink_on_s     = blink_on_r;
        frame_pulse_s  = 1'b0;
        case (mode_r)
            IDLE: begin
                if (enable) begin
                    mode_s         = SCAN;
                    prescaler_s    = '0;
                    index_s        = INDEX_FIRST;
                    shadow_s       = {column_4, column_3, column_2, column_1, column_0};
                    shadow_state_s = state;
                end else begin
                    mode_s = IDLE;
                end
            end
            SCAN: begin
                if (!enable) begin
                    // Leaving SCAN wins over any tick on this edge; the
                    // image latch is kept but timing restarts cleanly.
                    mode_s        = IDLE;
                    prescaler_s   = '0;
                    index_s       = INDEX_FIRST;
                    frame_count_s = '0;
                    blink_on_s    = 1'b1;
                end else if (prescaler_r == PRESCALE_LAST) begin
                    prescaler_s = '0;
                    if (index_r == 3'd0) begin
                        // Frame boundary: new image, new state, blink bookkeeping.
                        index_s        = INDEX_FIRST;
                        shadow_s       = {column_4, column_3, column_2, column_1, column_0};
                        shadow_state_s = state;
                        frame_pulse_s  = 1'b1;
                        if (frame_count_r == FRAME_LAST) begin
                            frame_count_s = '0;
                            blink_on_s    = ~blink_on_r;
                        end else begin
                            frame_count_s = frame_count_r + {{(FW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        index_s = index_r - 3'd1;
                    end
                end else begin
                    prescaler_s = prescaler_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                mode_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe (no extra cycle of latency).
    always_comb begin
        column_select_s = 5'b00000;
        row_s           = ROW_BLANK;
        if (mode_s == SCAN) begin
            column_select_s = 5'b00001 << index_s;
            if ((shadow_state_s == STATE_ERROR) && !blink_on_s) begin
                row_s = ROW_BLANK;
            end else begin
                row_s = shadow_s[index_s];
            end
        end else begin
            column_select_s = 5'b00000;
            row_s           = ROW_BLANK;
        end
    end

    // State, counter, image and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mode_r         <= IDLE;
            prescaler_r    <= '0;
            index_r        <= INDEX_FIRST;
            shadow_r       <= {5{ROW_BLANK}};
            shadow_state_r <= 3'b000;
            frame_count_r  <= '0;
            blink_on_r     <= 1'b1;
            column_select  <= 5'b00000;
            row            <= ROW_BLANK;
            frame_done     <= 1'b0;
        end else begin
            mode_r         <= mode_s;
            prescaler_r    <= prescaler_s;
            index_r        <= index_s;
            shadow_r       <= shadow_s;
            shadow_state_r <= shadow_state_s;
            frame_count_r  <= frame_count_s;
            blink_on_r     <= blink_on_s;
            column_select  <= column_select_s;
            row            <= row_s;
            frame_done     <= frame_pulse_s;
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner
//   Two scanner instances (N=4 and N=1, both B=2) share one set of inputs.
//   A reference model per instance tracks the cycle count since the scan
//   started and derives column, frame number, blink phase and frame pulse
//   arithmetically. Directed test-plan sequences run first, then random
//   stimulus.
module tb_matrix_column_scanner;

    localparam int B = 2;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [2:0] state;
    logic [6:0] col [0:4];
    logic [4:0] cs_a, cs_b;
    logic [6:0] row_a, row_b;
    logic       fd_a, fd_b;

    int tests_run;
    int tests_failed;

    // Reference model state, one entry per instance.
    int         n_of   [0:1];
    bit         act_m  [0:1];
    int         t_m    [0:1];
    logic [6:0] img_m  [0:1][0:4];
    logic [2:0] st_m   [0:1];

    matrix_column_scanner #(.CYCLES_PER_COLUMN(4), .BLINK_FRAMES(B)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .state(state),
        .column_4(col[4]), .column_3(col[3]), .column_2(col[2]),
        .column_1(col[1]), .column_0(col[0]),
        .column_select(cs_a), .row(row_a), .frame_done(fd_a)
    );

    matrix_column_scanner #(.CYCLES_PER_COLUMN(1), .BLINK_FRAMES(B)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .state(state),
        .column_4(col[4]), .column_3(col[3]), .column_2(col[2]),
        .column_1(col[1]), .column_0(col[0]),
        .column_select(cs_b), .row(row_b), .frame_done(fd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic latch_inputs(input int k);
        for (int i = 0; i < 5; i++) img_m[k][i] = col[i];
        st_m[k] = state;
    endtask

    // Advance the model of instance k by one rising edge.
    task automatic model_edge(input int k);
        if (!reset_n) begin
            act_m[k] = 1'b0;
        end else if (!act_m[k]) begin
            if (enable) begin
                act_m[k] = 1'b1;
                t_m[k]   = 0;
                latch_inputs(k);
            end
        end else if (!enable) begin
            act_m[k] = 1'b0;
        end else begin
            t_m[k]++;
            if (t_m[k] % (5 * n_of[k]) == 0) latch_inputs(k);
        end
    endtask

    task automatic check_unit(input int k, input logic [4:0] cs,
                              input logic [6:0] rw, input logic fd);
        logic [4:0] exp_cs;
        logic [6:0] exp_row;
        logic       exp_fd;
        int         idx;
        int         frame;
        exp_cs  = 5'b00000;
        exp_row = 7'h7F;
        exp_fd  = 1'b0;
        if (act_m[k]) begin
            idx    = 4 - ((t_m[k] / n_of[k]) % 5);
            frame  = t_m[k] / (5 * n_of[k]);
            exp_cs = 5'(1 << idx);
            exp_fd = (t_m[k] > 0) && (t_m[k] % (5 * n_of[k]) == 0);
            if (st_m[k] == 3'b010 && ((frame / B) % 2 == 1)) exp_row = 7'h7F;
            else exp_row = img_m[k][idx];
        end
        check_value($sformatf("u%0d_column_select", k), 32'(cs), 32'(exp_cs));
        check_value($sformatf("u%0d_row", k), 32'(rw), 32'(exp_row));
        check_value($sformatf("u%0d_frame_done", k), 32'(fd), 32'(exp_fd));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        check_unit(0, cs_a, row_a, fd_a);
        check_unit(1, cs_b, row_b, fd_b);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_of[0] = 4;
        n_of[1] = 1;
        act_m[0] = 1'b0;
        act_m[1] = 1'b0;
        t_m[0] = 0;
        t_m[1] = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        state   = 3'b000;
        col[4] = 7'h01; col[3] = 7'h02; col[2] = 7'h04; col[1] = 7'h08; col[0] = 7'h10;
        run(2);

        // Basic scan with a distinct pattern per column.
        reset_n = 1'b1;
        run(1);
        enable = 1'b1;
        run(8);
        // Mid-frame change must wait for the next frame boundary.
        col[4] = 7'h55;
        run(30);

        // Error state: blink over several frames.
        state = 3'b010;
        run(200);
        // Unused code passes through without blanking.
        state = 3'b011;
        run(130);

        // Drop enable mid-scan, then re-enable after a gap.
        state = 3'b000;
        run(9);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(12);
        // 1 -> 0 -> 1 on consecutive edges.
        enable = 1'b0;
        run(1);
        enable = 1'b1;
        run(25);
        // Enable falls exactly on a frame boundary of the N=4 unit.
        while (!(act_m[0] && (t_m[0] % 20 == 19))) step();
        enable = 1'b0;
        col[4] = 7'h2A;
        run(2);
        enable = 1'b1;
        run(6);

        // Reset mid-scan with enable held high.
        state = 3'b010;
        run(7);
        reset_n = 1'b0;
        run(1);
        reset_n = 1'b1;
        run(30);

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            else if ($urandom_range(0, 9) == 0) enable = 1'b1;
            if ($urandom_range(0, 7) == 0) col[$urandom_range(0, 4)] = 7'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 2))
                    0:       state = 3'b010;
                    1:       state = 3'($urandom);
                    default: state = 3'b011;
                endcase
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
